// File: rtl/pixel_row_readout.sv
// Pixel-array row readout: scans each row, waits for the bus to settle, samples it,
// and streams (pixel, row) beats out of a small first-word-fall-through FIFO.
module pixel_row_readout #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned N_ROWS     = 2,
    parameter int unsigned ROW_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              clr_ovf,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  row_sel,
    output logic              row_en,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_valid,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ROW_W-1:0] row_sel_nx;
    logic             row_en_nx;
    logic             frame_done_nx;
    logic             read_d;
    logic             start_c;
    logic             push_c;

    assign start_c = read && !read_d;

    // Scan sequencer state and registered row-drive outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            row_sel    <= '0;
            row_en     <= 1'b0;
            frame_done <= 1'b0;
            read_d     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            row_sel    <= row_sel_nx;
            row_en     <= row_en_nx;
            frame_done <= frame_done_nx;
            read_d     <= read;
        end
    end

    // Dropping read mid-scan abandons the current row without pushing it
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        row_sel_nx    = row_sel;
        row_en_nx     = row_en;
        frame_done_nx = 1'b0;
        push_c        = 1'b0;
        case (state)
            S_IDLE: begin
                row_en_nx  = 1'b0;
                row_sel_nx = '0;
                if (start_c) begin
                    state_nx  = S_SETTLE;
                    cnt_nx    = '0;
                    row_en_nx = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!read) begin
                    state_nx   = S_IDLE;
                    cnt_nx     = '0;
                    row_en_nx  = 1'b0;
                    row_sel_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nx = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (!read) begin
                    state_nx   = S_IDLE;
                    cnt_nx     = '0;
                    row_en_nx  = 1'b0;
                    row_sel_nx = '0;
                end else begin
                    push_c = 1'b1;
                    if (row_sel == ROW_LAST) begin
                        state_nx      = S_DONE;
                        row_en_nx     = 1'b0;
                        frame_done_nx = 1'b1;
                    end else begin
                        state_nx   = S_SETTLE;
                        cnt_nx     = '0;
                        row_sel_nx = row_sel + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nx   = S_IDLE;
                row_sel_nx = '0;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    entry_t            mem [FIFO_DEPTH];
    entry_t            push_ent;
    entry_t            head_nx;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
    logic [FILL_W-1:0] fill, fill_nx;
    logic              full_c;
    logic              pop_c;
    logic              wr_c;
    logic              drop_c;

    assign push_ent = {row_sel, pix_data};
    assign full_c   = (fill == FILL_MAX);
    assign pop_c    = out_valid && out_ready;
    assign wr_c     = push_c && (!full_c || pop_c);
    assign drop_c   = push_c && full_c && !pop_c;

    // Next head: a write landing on the new read slot bypasses the array
    always_comb begin
        rd_ptr_nx = pop_c ? rd_ptr + 1'b1 : rd_ptr;
        fill_nx   = fill;
        case ({wr_c, pop_c})
            2'b10:   fill_nx = fill + 1'b1;
            2'b01:   fill_nx = fill - 1'b1;
            default: fill_nx = fill;
        endcase
        head_nx = (wr_c && (wr_ptr == rd_ptr_nx)) ? push_ent : mem[rd_ptr_nx];
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    // FIFO bookkeeping, registered head view and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr    <= rd_ptr_nx;
            fill      <= fill_nx;
            out_valid <= (fill_nx != '0);
            if (fill_nx != '0) begin
                out_data <= head_nx.data;
                out_row  <= head_nx.row;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: a 2-row and an 8-row instance, a settling pixel-bus
// model, and per-instance scoreboards of expected (pixel, row) beats.
module tb_pixel_row_readout;

    localparam int unsigned SETTLE = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] row;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: 2 rows
    logic       read_a, clr_ovf_a, out_ready_a;
    logic [7:0] pix_a;
    logic [0:0] row_sel_a, out_row_a;
    logic       row_en_a, out_valid_a, frame_done_a, overflow_a;
    logic [7:0] out_data_a;
    logic [7:0] pat_a [2];

    // Instance B: 8 rows
    logic       read_b, clr_ovf_b, out_ready_b;
    logic [7:0] pix_b;
    logic [2:0] row_sel_b, out_row_b;
    logic       row_en_b, out_valid_b, frame_done_b, overflow_b;
    logic [7:0] out_data_b;
    logic [7:0] pat_b [8];

    beat_t q_a [$];
    beat_t q_b [$];
    beat_t e_a, e_b;
    int    beats_a = 0;
    int    beats_b = 0;

    pixel_row_readout #(.DATA_W(8), .N_ROWS(2), .ROW_W(1), .SETTLE(SETTLE), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_n), .read(read_a), .pix_data(pix_a), .clr_ovf(clr_ovf_a),
        .out_ready(out_ready_a), .row_sel(row_sel_a), .row_en(row_en_a), .out_data(out_data_a),
        .out_row(out_row_a), .out_valid(out_valid_a), .frame_done(frame_done_a), .overflow(overflow_a)
    );

    pixel_row_readout #(.DATA_W(8), .N_ROWS(8), .ROW_W(3), .SETTLE(SETTLE), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(rst_n), .read(read_b), .pix_data(pix_b), .clr_ovf(clr_ovf_b),
        .out_ready(out_ready_b), .row_sel(row_sel_b), .row_en(row_en_b), .out_data(out_data_b),
        .out_row(out_row_b), .out_valid(out_valid_b), .frame_done(frame_done_b), .overflow(overflow_b)
    );

    // Pixel bus model: shows garbage until the row has been enabled for SETTLE cycles
    int         held_a = 0, held_b = 0;
    logic [0:0] last_sel_a = '0;
    logic [2:0] last_sel_b = '0;
    always @(posedge clk) begin
        if (!row_en_a) held_a <= 0;
        else if (row_sel_a != last_sel_a) held_a <= 1;
        else held_a <= held_a + 1;
        last_sel_a <= row_sel_a;
        if (!row_en_b) held_b <= 0;
        else if (row_sel_b != last_sel_b) held_b <= 1;
        else held_b <= held_b + 1;
        last_sel_b <= row_sel_b;
    end
    assign pix_a = (row_en_a && held_a >= SETTLE) ? pat_a[row_sel_a] : 8'hEE;
    assign pix_b = (row_en_b && held_b >= SETTLE) ? pat_b[row_sel_b] : 8'hEE;

    // Scoreboard: every accepted beat is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            checks++;
            beats_a++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL beat_a unexpected: got data=%h row=%0d, required no beat", out_data_a, out_row_a);
            end else begin
                e_a = q_a.pop_front();
                if (out_data_a !== e_a.data || 8'(out_row_a) !== e_a.row) begin
                    errors++;
                    $display("FAIL beat_a: got data=%h row=%0d, required data=%h row=%0d",
                             out_data_a, out_row_a, e_a.data, e_a.row);
                end
            end
        end
        if (rst_n && out_valid_b && out_ready_b) begin
            checks++;
            beats_b++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL beat_b unexpected: got data=%h row=%0d, required no beat", out_data_b, out_row_b);
            end else begin
                e_b = q_b.pop_front();
                if (out_data_b !== e_b.data || 8'(out_row_b) !== e_b.row) begin
                    errors++;
                    $display("FAIL beat_b: got data=%h row=%0d, required data=%h row=%0d",
                             out_data_b, out_row_b, e_b.data, e_b.row);
                end
            end
        end
    end

    function automatic beat_t mk(input logic [7:0] d, input int r);
        beat_t b;
        b.data = d;
        b.row  = 8'(r);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame_a();
        read_a = 1'b1;
        repeat (7) tick();
        read_a = 1'b0;
        tick();
    endtask

    task automatic drain(input bit sel_b, input string name);
        if (sel_b) out_ready_b = 1'b1;
        else out_ready_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sel_b ? (q_b.size() == 0 && !out_valid_b) : (q_a.size() == 0 && !out_valid_a)) break;
            tick();
        end
        checks++;
        if (sel_b ? (q_b.size() != 0 || out_valid_b !== 1'b0) : (q_a.size() != 0 || out_valid_a !== 1'b0)) begin
            errors++;
            $display("FAIL %s drain: got pending=%0d out_valid=%b, required pending=0 out_valid=0",
                     name, sel_b ? q_b.size() : q_a.size(), sel_b ? out_valid_b : out_valid_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        read_a = 0; clr_ovf_a = 0; out_ready_a = 0;
        read_b = 0; clr_ovf_b = 0; out_ready_b = 0;
        for (int r = 0; r < 2; r++) pat_a[r] = 8'h00;
        for (int r = 0; r < 8; r++) pat_b[r] = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({row_sel_a, row_en_a, out_data_a, out_row_a, out_valid_a, frame_done_a, overflow_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs: got %b, required all zero",
                     {row_sel_a, row_en_a, out_data_a, out_row_a, out_valid_a, frame_done_a, overflow_a});
        end
        checks++;
        if ({row_sel_b, row_en_b, out_data_b, out_row_b, out_valid_b, frame_done_b, overflow_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs: got %b, required all zero",
                     {row_sel_b, row_en_b, out_data_b, out_row_b, out_valid_b, frame_done_b, overflow_b});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (row_en_a !== 1'b0 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got row_en=%b out_valid=%b, required 0 0", row_en_a, out_valid_a);
        end
    endtask

    task automatic test_basic_frame();
        pat_a[0] = 8'h80;
        pat_a[1] = 8'h3C;
        out_ready_a = 1'b1;
        q_a.push_back(mk(8'h80, 0));
        q_a.push_back(mk(8'h3C, 1));
        read_a = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            tick();
            checks++;
            if (row_en_a !== (c <= 5)) begin
                errors++;
                $display("FAIL basic row_en c%0d: got %b, required %b", c, row_en_a, (c <= 5));
            end
            checks++;
            if (frame_done_a !== (c == 6)) begin
                errors++;
                $display("FAIL basic frame_done c%0d: got %b, required %b", c, frame_done_a, (c == 6));
            end
            if (c <= 5) begin
                checks++;
                if (row_sel_a !== 1'((c >= 3) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL basic row_sel c%0d: got %0d, required %0d", c, row_sel_a, (c >= 3) ? 1 : 0);
                end
            end
            if (c == 3) begin
                checks++;
                if (out_valid_a !== 1'b1) begin
                    errors++;
                    $display("FAIL basic out_valid c3: got %b, required 1", out_valid_a);
                end
            end
        end
        read_a = 1'b0;
        tick();
        checks++;
        if (frame_done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic frame_done pulse: got %b, required 0", frame_done_a);
        end
        drain(1'b0, "basic");
    endtask

    task automatic test_back_pressure();
        int snap;
        out_ready_b = 1'b0;
        for (int r = 0; r < 8; r++) pat_b[r] = 8'(r * 8'h11);
        for (int r = 0; r < 4; r++) q_b.push_back(mk(8'(r * 8'h11), r));
        read_b = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            tick();
            if (c == 14 || c == 15) begin
                checks++;
                if (overflow_b !== (c == 15)) begin
                    errors++;
                    $display("FAIL backpr overflow c%0d: got %b, required %b", c, overflow_b, (c == 15));
                end
            end
            if (c == 24) begin
                checks++;
                if (frame_done_b !== 1'b1) begin
                    errors++;
                    $display("FAIL backpr frame_done c24: got %b, required 1", frame_done_b);
                end
            end
        end
        read_b = 1'b0;
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || overflow_b !== 1'b1) begin
            errors++;
            $display("FAIL backpr held: got out_valid=%b overflow=%b, required 1 1", out_valid_b, overflow_b);
        end
        snap = beats_b;
        drain(1'b1, "backpr");
        checks++;
        if (beats_b - snap !== 4) begin
            errors++;
            $display("FAIL backpr kept entries: got %0d, required 4", beats_b - snap);
        end
        clr_ovf_b = 1'b1;
        tick();
        clr_ovf_b = 1'b0;
        checks++;
        if (overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL backpr clr_ovf: got %b, required 0", overflow_b);
        end
    endtask

    task automatic test_full_push_pop();
        int snap;
        out_ready_a = 1'b0;
        pat_a[0] = 8'h10; pat_a[1] = 8'h11;
        q_a.push_back(mk(8'h10, 0)); q_a.push_back(mk(8'h11, 1));
        run_frame_a();
        pat_a[0] = 8'h20; pat_a[1] = 8'h21;
        q_a.push_back(mk(8'h20, 0)); q_a.push_back(mk(8'h21, 1));
        run_frame_a();
        pat_a[0] = 8'h30; pat_a[1] = 8'h31;
        q_a.push_back(mk(8'h30, 0));
        read_a = 1'b1;
        repeat (3) tick();
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        read_a = 1'b0;
        tick();
        checks++;
        if (overflow_a !== 1'b0 || row_en_a !== 1'b0) begin
            errors++;
            $display("FAIL fullpp state: got overflow=%b row_en=%b, required 0 0", overflow_a, row_en_a);
        end
        snap = beats_a;
        drain(1'b0, "fullpp");
        checks++;
        if (beats_a - snap !== 4) begin
            errors++;
            $display("FAIL fullpp count: got %0d, required 4", beats_a - snap);
        end
    endtask

    task automatic test_abort();
        out_ready_a = 1'b1;
        pat_a[0] = 8'h44; pat_a[1] = 8'h55;
        q_a.push_back(mk(8'h44, 0));
        read_a = 1'b1;
        repeat (4) tick();
        checks++;
        if (row_sel_a !== 1'b1 || row_en_a !== 1'b1) begin
            errors++;
            $display("FAIL abort pre: got row_sel=%0d row_en=%b, required 1 1", row_sel_a, row_en_a);
        end
        read_a = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            tick();
            checks++;
            if (frame_done_a !== 1'b0 || row_en_a !== 1'b0 || row_sel_a !== 1'b0) begin
                errors++;
                $display("FAIL abort c%0d: got frame_done=%b row_en=%b row_sel=%0d, required 0 0 0",
                         c, frame_done_a, row_en_a, row_sel_a);
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL abort row0 beat: got pending=%0d, required 0", q_a.size());
        end
        q_a.push_back(mk(8'h44, 0));
        q_a.push_back(mk(8'h55, 1));
        read_a = 1'b1;
        tick();
        checks++;
        if (row_en_a !== 1'b1 || row_sel_a !== 1'b0) begin
            errors++;
            $display("FAIL abort restart: got row_en=%b row_sel=%0d, required 1 0", row_en_a, row_sel_a);
        end
        repeat (6) tick();
        checks++;
        if (frame_done_a !== 1'b1) begin
            errors++;
            $display("FAIL abort restart frame_done: got %b, required 1", frame_done_a);
        end
        read_a = 1'b0;
        tick();
        drain(1'b0, "abort");
    endtask

    task automatic test_reset_mid_frame();
        out_ready_a = 1'b0;
        pat_a[0] = 8'h66; pat_a[1] = 8'h77;
        read_a = 1'b1;
        repeat (6) tick();
        checks++;
        if (out_valid_a !== 1'b1 || row_en_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: got out_valid=%b row_en=%b, required 1 1", out_valid_a, row_en_a);
        end
        #2;
        rst_n = 1'b0;
        read_a = 1'b0;
        #1;
        checks++;
        if ({row_sel_a, row_en_a, out_data_a, out_row_a, out_valid_a, frame_done_a, overflow_a} !== '0) begin
            errors++;
            $display("FAIL midrst outputs: got %b, required all zero",
                     {row_sel_a, row_en_a, out_data_a, out_row_a, out_valid_a, frame_done_a, overflow_a});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (row_en_a !== 1'b0 || out_valid_a !== 1'b0) begin
                errors++;
                $display("FAIL midrst idle c%0d: got row_en=%b out_valid=%b, required 0 0", c, row_en_a, out_valid_a);
            end
        end
        out_ready_a = 1'b1;
        q_a.push_back(mk(8'h66, 0));
        q_a.push_back(mk(8'h77, 1));
        run_frame_a();
        drain(1'b0, "midrst");
    endtask

    task automatic test_overflow_race();
        out_ready_a = 1'b0;
        pat_a[0] = 8'h81; pat_a[1] = 8'h82;
        q_a.push_back(mk(8'h81, 0)); q_a.push_back(mk(8'h82, 1));
        run_frame_a();
        pat_a[0] = 8'h91; pat_a[1] = 8'h92;
        q_a.push_back(mk(8'h91, 0)); q_a.push_back(mk(8'h92, 1));
        run_frame_a();
        pat_a[0] = 8'hA1; pat_a[1] = 8'hA2;
        read_a = 1'b1;
        repeat (3) tick();
        checks++;
        if (overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL ovfrace before drop: got %b, required 0", overflow_a);
        end
        clr_ovf_a = 1'b1;
        tick();
        clr_ovf_a = 1'b0;
        read_a = 1'b0;
        checks++;
        if (overflow_a !== 1'b1) begin
            errors++;
            $display("FAIL ovfrace set wins: got %b, required 1", overflow_a);
        end
        tick();
        checks++;
        if (overflow_a !== 1'b1) begin
            errors++;
            $display("FAIL ovfrace sticky: got %b, required 1", overflow_a);
        end
        clr_ovf_a = 1'b1;
        tick();
        clr_ovf_a = 1'b0;
        checks++;
        if (overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL ovfrace clear: got %b, required 0", overflow_a);
        end
        drain(1'b0, "ovfrace");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_full_push_pop();
        test_abort();
        test_reset_mid_frame();
        test_overflow_race();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
